// File: rtl/lif_neuron.sv
`default_nettype none
// ============================================================================
// Module      : lif_neuron
// Description : Leaky integrate-and-fire neuron with a signed Q(VW-7).7
//               membrane potential, saturating integration, threshold firing,
//               post-spike refractory period and a saturating spike counter.
//               Optional feature macro: LIF_LEAK_EN
//                 defined   -> leak = v_mem >>> LEAK_SHIFT on every accept
//                 undefined -> leak = 0 (pure integrate-and-fire)
// Revision    : 1.0 - initial release
// ============================================================================
module lif_neuron #(
    parameter int VW            = 16,
    parameter int THRESH        = 256,
    parameter int V_RESET       = 0,
    parameter int LEAK_SHIFT    = 4,
    parameter int REFRAC_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [7:0]           in_current,
    output logic                 in_ready,
    output logic                 spike,
    output logic [VW-1:0]        v_mem,
    output logic [15:0]          spike_count,
    output logic                 refractory
);

    // Extended width gives two guard bits so the sum never wraps before clamping.
    localparam int EW = VW + 2;

    localparam logic signed [EW-1:0] c_VMAX    = {3'b000, {(VW-1){1'b1}}};
    localparam logic signed [EW-1:0] c_VMIN    = {3'b111, {(VW-1){1'b0}}};
    localparam logic signed [EW-1:0] c_THRESH  = EW'(THRESH);
    localparam logic signed [VW-1:0] c_V_RESET = VW'(V_RESET);
    localparam logic        [7:0]    c_REFRAC  = 8'(REFRAC_CYCLES);
    localparam logic        [15:0]   c_CNT_MAX = 16'hFFFF;

    typedef enum logic [0:0] {
        ST_INTEGRATE = 1'b0,
        ST_REFRACT   = 1'b1
    } state_t;

    // Elaboration-time parameter range checks.
    if (LEAK_SHIFT < 1 || LEAK_SHIFT > VW - 1) begin : g_leak_shift_chk
        $error("lif_neuron: LEAK_SHIFT out of range 1..VW-1");
    end
    if (REFRAC_CYCLES < 0 || REFRAC_CYCLES > 255) begin : g_refrac_chk
        $error("lif_neuron: REFRAC_CYCLES out of range 0..255");
    end

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [7:0]             r_refrac_cnt;
    logic [7:0]             w_refrac_cnt_nxt;
    logic signed [VW-1:0]   r_v_mem;
    logic signed [VW-1:0]   w_v_mem_nxt;
    logic                   r_spike;
    logic                   w_spike_nxt;
    logic [15:0]            r_spike_count;
    logic [15:0]            w_spike_count_nxt;

    logic                   w_ready;
    logic                   w_accept;
    logic signed [VW-1:0]   w_leak;
    logic signed [EW-1:0]   w_sum;
    logic signed [EW-1:0]   w_sat;
    logic signed [VW-1:0]   w_v_next;
    logic                   w_fire;

    assign w_ready  = (r_state == ST_INTEGRATE);
    assign w_accept = in_valid & w_ready;

`ifdef LIF_LEAK_EN
    // Leak proportional to the present potential, rounding toward -inf.
    assign w_leak = r_v_mem >>> LEAK_SHIFT;
`else
    assign w_leak = '0;
`endif

    // Q1.7 input already shares the 7 fractional bits, so plain sign
    // extension aligns it with the membrane potential.
    assign w_sum = {{2{r_v_mem[VW-1]}}, r_v_mem}
                 - {{2{w_leak[VW-1]}}, w_leak}
                 + {{(EW-8){in_current[7]}}, in_current};

    // Clamp to the representable VW-bit signed range.
    always_comb begin
        w_sat = w_sum;
        if (w_sum > c_VMAX) begin
            w_sat = c_VMAX;
        end else if (w_sum < c_VMIN) begin
            w_sat = c_VMIN;
        end
    end

    assign w_v_next = w_sat[VW-1:0];
    assign w_fire   = (w_sat >= c_THRESH);

    // Next-state, integration, firing and refractory countdown.
    always_comb begin
        w_state_nxt       = r_state;
        w_refrac_cnt_nxt  = r_refrac_cnt;
        w_v_mem_nxt       = r_v_mem;
        w_spike_nxt       = 1'b0;
        w_spike_count_nxt = r_spike_count;
        case (r_state)
            ST_INTEGRATE: begin
                if (w_accept) begin
                    if (w_fire) begin
                        w_v_mem_nxt = c_V_RESET;
                        w_spike_nxt = 1'b1;
                        if (r_spike_count != c_CNT_MAX) begin
                            w_spike_count_nxt = r_spike_count + 16'd1;
                        end
                        // A zero-length refractory period keeps integrating.
                        if (REFRAC_CYCLES > 0) begin
                            w_state_nxt      = ST_REFRACT;
                            w_refrac_cnt_nxt = c_REFRAC;
                        end
                    end else begin
                        w_v_mem_nxt = w_v_next;
                    end
                end
            end
            ST_REFRACT: begin
                // The cycle on which the counter reads 1 is the last blocked one.
                if (r_refrac_cnt <= 8'd1) begin
                    w_state_nxt      = ST_INTEGRATE;
                    w_refrac_cnt_nxt = 8'd0;
                end else begin
                    w_refrac_cnt_nxt = r_refrac_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt      = ST_INTEGRATE;
                w_refrac_cnt_nxt = 8'd0;
            end
        endcase
    end

    // State register; reset overrides every other update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_INTEGRATE;
            r_refrac_cnt  <= 8'd0;
            r_v_mem       <= '0;
            r_spike       <= 1'b0;
            r_spike_count <= 16'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_refrac_cnt  <= w_refrac_cnt_nxt;
            r_v_mem       <= w_v_mem_nxt;
            r_spike       <= w_spike_nxt;
            r_spike_count <= w_spike_count_nxt;
        end
    end

    assign in_ready    = w_ready;
    assign refractory  = (r_state == ST_REFRACT);
    assign spike       = r_spike;
    assign v_mem       = r_v_mem;
    assign spike_count = r_spike_count;

endmodule
`default_nettype wire

// File: tb/tb_lif_neuron.sv
`default_nettype none
// ============================================================================
// Module      : tb_lif_neuron
// Description : Self-checking bench for lif_neuron. Two instances share the
//               same stimulus: index 0 has no refractory period, index 1 uses
//               the default of 3 cycles. A behavioural model tracks both.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lif_neuron;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [7:0]       in_current;
    logic [1:0]       d_ready;
    logic [1:0]       d_spike;
    logic [1:0]       d_refr;
    logic [1:0][15:0] d_v;
    logic [1:0][15:0] d_cnt;

    int checks   = 0;
    int failures = 0;

    lif_neuron #(.REFRAC_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_current(in_current),
        .in_ready(d_ready[0]), .spike(d_spike[0]), .v_mem(d_v[0]),
        .spike_count(d_cnt[0]), .refractory(d_refr[0])
    );

    lif_neuron u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_current(in_current),
        .in_ready(d_ready[1]), .spike(d_spike[1]), .v_mem(d_v[1]),
        .spike_count(d_cnt[1]), .refractory(d_refr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Behavioural model: potential as a plain integer, refractory period as
    // a count of remaining blocked cycles.
    int m_v[2];
    int m_cnt[2];
    int m_blk[2];
    int m_spk[2];
    bit m_live = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int nv;
            int lk;
            if (rst) begin
                m_v[i] = 0; m_cnt[i] = 0; m_blk[i] = 0; m_spk[i] = 0;
            end else begin
                m_spk[i] = 0;
                if (m_blk[i] > 0) begin
                    m_blk[i] = m_blk[i] - 1;
                end else if (in_valid) begin
`ifdef LIF_LEAK_EN
                    lk = m_v[i] >>> 4;
`else
                    lk = 0;
`endif
                    nv = m_v[i] - lk + int'($signed(in_current));
                    if (nv > 32767)  nv = 32767;
                    if (nv < -32768) nv = -32768;
                    if (nv >= 256) begin
                        m_v[i]   = 0;
                        m_spk[i] = 1;
                        if (m_cnt[i] < 65535) m_cnt[i] = m_cnt[i] + 1;
                        m_blk[i] = (i == 0) ? 0 : 3;
                    end else begin
                        m_v[i] = nv;
                    end
                end
            end
        end
        if (rst) m_live = 1'b1;
        #1;
        if (m_live) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("model_v_mem[%0d]", i), int'($signed(d_v[i])), m_v[i]);
                chk($sformatf("model_spike[%0d]", i), int'(d_spike[i]), m_spk[i]);
                chk($sformatf("model_count[%0d]", i), int'(d_cnt[i]), m_cnt[i]);
                chk($sformatf("model_ready[%0d]", i), int'(d_ready[i]), (m_blk[i] == 0) ? 1 : 0);
                chk($sformatf("model_refr[%0d]", i), int'(d_refr[i]), (m_blk[i] != 0) ? 1 : 0);
            end
        end
    end

    // One clock of stimulus; returns just after the model comparison.
    task automatic step(input logic r, input logic v, input logic [7:0] c);
        @(negedge clk);
        rst        = r;
        in_valid   = v;
        in_current = c;
        @(posedge clk);
        #2;
    endtask

    logic [7:0] pat [12] = '{8'h10, 8'hF0, 8'h7F, 8'h7F, 8'h85, 8'h00,
                             8'h7F, 8'h60, 8'h7F, 8'h81, 8'h7F, 8'h7F};

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_current = 8'h00;
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        chk("reset_v_mem", int'($signed(d_v[1])), 0);
        chk("reset_ready", int'(d_ready[1]), 1);
        chk("reset_count", int'(d_cnt[1]), 0);

`ifndef LIF_LEAK_EN
        step(1'b0, 1'b1, 8'h40); chk("if_acc1", int'($signed(d_v[0])), 64);
        step(1'b0, 1'b1, 8'h40); chk("if_acc2", int'($signed(d_v[0])), 128);
        step(1'b0, 1'b1, 8'h40); chk("if_acc3", int'($signed(d_v[0])), 192);
        step(1'b0, 1'b1, 8'h40);
`else
        step(1'b0, 1'b1, 8'h40); chk("lif_acc1", int'($signed(d_v[0])), 64);
        step(1'b0, 1'b1, 8'h40); chk("lif_acc2", int'($signed(d_v[0])), 124);
        step(1'b0, 1'b1, 8'h40); chk("lif_acc3", int'($signed(d_v[0])), 181);
        step(1'b0, 1'b1, 8'h40); chk("lif_acc4", int'($signed(d_v[0])), 234);
        step(1'b0, 1'b1, 8'h40);
`endif
        chk("fire_spike", int'(d_spike[0]), 1);
        chk("fire_v_mem", int'($signed(d_v[0])), 0);
        chk("fire_count", int'(d_cnt[0]), 1);
        chk("fire_ready_r3", int'(d_ready[1]), 0);
        chk("fire_refr_r3", int'(d_refr[1]), 1);
        chk("fire_ready_r0", int'(d_ready[0]), 1);

        // Input held valid during the refractory window must be ignored.
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 8'h7F);
            chk($sformatf("refr_v_hold%0d", k), int'($signed(d_v[1])), 0);
            chk($sformatf("refr_ready%0d", k), int'(d_ready[1]), (k < 2) ? 0 : 1);
        end
        step(1'b0, 1'b1, 8'h7F);
        chk("post_refr_add", int'($signed(d_v[1])), 127);

        // Fire again, then reset in the second refractory cycle.
        step(1'b0, 1'b1, 8'h7F);
        step(1'b0, 1'b1, 8'h7F);
        chk("refire_spike", int'(d_spike[1]), 1);
        chk("refire_count", int'(d_cnt[1]), 2);
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        chk("rst_refr_v", int'($signed(d_v[1])), 0);
        chk("rst_refr_count", int'(d_cnt[1]), 0);
        chk("rst_refr_ready", int'(d_ready[1]), 1);
        chk("rst_refr_refr", int'(d_refr[1]), 0);

        // Reset wins over a valid sample.
        step(1'b1, 1'b1, 8'h7F);
        chk("rst_acc_v1", int'($signed(d_v[1])), 0);
        chk("rst_acc_v0", int'($signed(d_v[0])), 0);
        chk("rst_acc_spike", int'(d_spike[1]), 0);

        // Mixed currents and valid gaps, checked against the model.
        for (int i = 0; i < 24; i++) begin
            step(1'b0, (i % 3) != 2, pat[i % 12]);
        end

        // Sustained maximum negative drive.
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1, 8'h80);
`ifndef LIF_LEAK_EN
            if (i == 254) chk("neg_acc255", int'($signed(d_v[1])), -32640);
            if (i == 255) chk("neg_acc256", int'($signed(d_v[1])), -32768);
`endif
        end
`ifndef LIF_LEAK_EN
        chk("neg_final_v", int'($signed(d_v[1])), -32768);
`endif
        chk("neg_no_spike", int'(d_cnt[1]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
